gshare_branch_predictor: RTL

- Direction predictor for the fetch stage.
- It is the consumer end of the execute stage's branch-resolution outputs (isBranch, branchTaken, isBranchTakenPredicted).
- Fetch side: hashes the fetch PC with a global history register (GHR) into a table of 2-bit saturating counters and returns a taken/not-taken prediction plus the index used.
- Execute side: the resolved outcome and the carried index train the table one cycle later, shift the GHR, and count mispredictions.

---
 rtl/gshare_branch_predictor.sv | 114 +++++++++++
 1 files changed

// File: rtl/gshare_branch_predictor.sv
// gshare direction predictor: PC xor global history indexes a table of 2-bit
// saturating counters. Resolved branches from execute are captured into an
// update register and committed to the table and history one cycle later.
module gshare_branch_predictor #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INDEX_WIDTH = 8,
    parameter int unsigned GHR_WIDTH   = 8,
    parameter logic [1:0]  CNT_RESET   = 2'b01
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_WIDTH-1:0]    fetchPc,
    output logic                   predictTaken,
    output logic [INDEX_WIDTH-1:0] predictIndex,
    input  logic                   exValid,
    input  logic                   exIsBranch,
    input  logic                   exBranchTaken,
    input  logic                   exIsBranchTakenPredicted,
    input  logic [INDEX_WIDTH-1:0] exPredictIndex,
    output logic [GHR_WIDTH-1:0]   ghr,
    output logic [31:0]            mispredictCount
);

    localparam int unsigned NumEntries = 1 << INDEX_WIDTH;

    logic [1:0]             counterTable [NumEntries];
    logic                   updV;
    logic [INDEX_WIDTH-1:0] updIdx;
    logic                   updTaken;
    logic [INDEX_WIDTH-1:0] fetchIdx;
    logic [1:0]             updNext;
    logic [1:0]             effCnt;
    logic [GHR_WIDTH-1:0]   nextGhr;
    logic                   captureEn;
    logic                   unusedPcBits;

    // Saturating +/-1 step of a 2-bit counter
    function automatic logic [1:0] satStep(input logic [1:0] cnt, input logic up);
        if (up) begin
            return (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end
        return (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    endfunction

    // PC word bits outside the index field do not participate in the hash
    assign unusedPcBits = ^{fetchPc[PC_WIDTH-1:INDEX_WIDTH+2], fetchPc[1:0]};

    assign captureEn    = exValid & exIsBranch;
    assign fetchIdx     = fetchPc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(ghr);
    assign predictIndex = fetchIdx;
    assign updNext      = satStep(counterTable[updIdx], updTaken);

    // Prediction read with bypass of the counter being committed this cycle
    always_comb begin
        effCnt = counterTable[fetchIdx];
        if (updV && (fetchIdx == updIdx)) begin
            effCnt = updNext;
        end
    end

    assign predictTaken = effCnt[1];

    // History shift in the committed outcome
    generate
        if (GHR_WIDTH == 1) begin : gSingleGhr
            assign nextGhr = updTaken;
        end else begin : gMultiGhr
            assign nextGhr = {ghr[GHR_WIDTH-2:0], updTaken};
        end
    endgenerate

    // Counter table: commit pending update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NumEntries); i++) begin
                counterTable[i] <= CNT_RESET;
            end
        end else if (updV) begin
            counterTable[updIdx] <= updNext;
        end
    end

    // Global history register advances on commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr <= '0;
        end else if (updV) begin
            ghr <= nextGhr;
        end
    end

    // Capture a resolved conditional branch for commit next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            updV     <= 1'b0;
            updIdx   <= '0;
            updTaken <= 1'b0;
        end else begin
            updV     <= captureEn;
            updIdx   <= exPredictIndex;
            updTaken <= exBranchTaken;
        end
    end

    // Mispredict counter, counted at capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredictCount <= 32'd0;
        end else if (captureEn && (exBranchTaken != exIsBranchTakenPredicted)) begin
            mispredictCount <= mispredictCount + 32'd1;
        end
    end

endmodule
